// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: widths, the canonical NOP, reset vector
// and the fetch FSM state constants.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [0:0] fetch_state_e;
    localparam fetch_state_e RUN  = 1'b0;
    localparam fetch_state_e HOLD = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ibuf_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave). Responses are in order with no backpressure.
interface fetch_unit_if;
    import rv32i_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_ibuf.sv
// Synchronous FIFO of {pc, instr} pairs with flush; flush wins over a
// same-cycle push and pop.
module fetch_ibuf
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  ibuf_entry_t            push_data_i,
    input  logic                   pop_i,
    output ibuf_entry_t            head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    ibuf_entry_t   mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + (AW+1)'(1);
            if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // When full, a simultaneous push overwrites the slot being popped this cycle.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order word fetches under a credit
// limit, buffers responses and restarts cleanly at branch-unit redirects.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jmp_occur,
    input  logic [XLEN-1:0]   pc_jmpto,
    fetch_unit_if.master      imem,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   pc_current
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(IBUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            redir;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] jmp_target;
    logic [1:0]      unused_jmp_lsb;
    logic [31:0]     inflight;
    logic [CW-1:0]   ibuf_count;
    logic            ibuf_full;
    logic            ibuf_empty;
    ibuf_entry_t     ibuf_head;

    assign jmp_target     = {pc_jmpto[XLEN-1:2], 2'b00};
    assign unused_jmp_lsb = pc_jmpto[1:0];

    // HOLD only matters while jmp_occur stays high; the first low cycle
    // already behaves as RUN so the restart fetch goes out right away.
    assign redir    = jmp_occur && (state_q == RUN);
    assign inflight = 32'(outstanding_q) + 32'(ibuf_count);

    assign imem.imem_req_valid = !rst && !jmp_occur
                               && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
                               && (inflight < 32'(IBUF_DEPTH));
    assign imem.imem_req_addr  = fetch_pc_q;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    assign push = imem.imem_rsp_valid && (drop_cnt_q == '0) && !redir;

    assign instr_valid = !ibuf_empty && !jmp_occur;
    assign pop         = instr_valid && instr_ready;
    assign instr       = ibuf_empty ? RV_NOP   : ibuf_head.instr;
    assign pc_current  = ibuf_empty ? rsp_pc_q : ibuf_head.pc;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem.imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;

        if (state_q == RUN) begin
            if (redir) state_d = HOLD;
        end else if (!jmp_occur) begin
            state_d = RUN;
        end

        // Every response still owed after this cycle belongs to the old stream.
        if (redir) begin
            fetch_pc_d = jmp_target;
            rsp_pc_d   = jmp_target;
            drop_cnt_d = outstanding_q - OW'(imem.imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = pc_next(fetch_pc_q);
            if (push)     rsp_pc_d   = pc_next(rsp_pc_q);
            if (imem.imem_rsp_valid && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redir),
        .push_i      (push),
        .push_data_i ('{pc: rsp_pc_q, instr: imem.imem_rsp_data}),
        .pop_i       (pop),
        .head_o      (ibuf_head),
        .count_o     (ibuf_count),
        .full_o      (ibuf_full),
        .empty_o     (ibuf_empty)
    );

    a_outstanding_max: assert property (@(posedge clk) disable iff (rst)
        32'(outstanding_q) <= 32'(MAX_OUTSTANDING));

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && ibuf_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order imem model plus a stream-level model of
// the expected fetch addresses and decode sequence, with directed scenarios.
module tb_fetch_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        jmp_occur;
    logic [31:0] pc_jmpto;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_current;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .IBUF_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jmp_occur   (jmp_occur),
        .pc_jmpto    (pc_jmpto),
        .imem        (bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_current  (pc_current)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pending[$];
    req_t        rspEntry;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] mFetchPc;
    logic [31:0] mDecPc;
    int          mOut;
    int          mOcc;
    logic        jmpPrev;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: answers requests in order once their latency has elapsed.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memWord(pending[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
    end

    // Stream model: fetch addresses and decode PCs advance by 4 and restart at
    // the target of each new jmp_occur pulse; responses issued before it are lost.
    always @(negedge clk) begin
        if (rst) begin
            pending.delete();
            mFetchPc = 32'h0;
            mDecPc   = 32'h0;
            mOut     = 0;
            mOcc     = 0;
            jmpPrev  = 1'b0;
            epoch    = epoch + 1;
        end else begin
            checkOutput("req_valid", {31'b0, bus.imem_req_valid},
                        {31'b0, !jmp_occur && mOut < 2 && (mOut + mOcc) < 4});
            checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, mOcc > 0 && !jmp_occur});
            if (instr_valid && instr_ready) begin
                checkOutput("pc_current", pc_current, mDecPc);
                checkOutput("instr", instr, memWord(mDecPc));
                mDecPc = mDecPc + 32'd4;
                mOcc   = mOcc - 1;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                checkOutput("req_addr", bus.imem_req_addr, mFetchPc);
                pending.push_back('{mFetchPc, epoch, cyc + lat});
                mFetchPc = mFetchPc + 32'd4;
                mOut     = mOut + 1;
            end
            if (bus.imem_rsp_valid) begin
                if (pending.size() == 0) begin
                    checkOutput("rsp_without_req", 32'd1, 32'd0);
                end else begin
                    rspEntry = pending.pop_front();
                    mOut = mOut - 1;
                    if (rspEntry.epoch == epoch) mOcc = mOcc + 1;
                end
            end
            if (jmp_occur && !jmpPrev) begin
                epoch    = epoch + 1;
                mOcc     = 0;
                mFetchPc = {pc_jmpto[31:2], 2'b00};
                mDecPc   = {pc_jmpto[31:2], 2'b00};
            end
            jmpPrev = jmp_occur;
        end
    end

    task automatic applyStimulus(input logic jmp, input logic [31:0] tgt, input int n);
        jmp_occur = jmp;
        pc_jmpto  = tgt;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the negedge where instr_valid is first seen high.
    task automatic waitValid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
        end
        if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst                = 1'b1;
        jmp_occur          = 1'b0;
        pc_jmpto           = 32'h0;
        instr_ready        = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("rst_instr", instr, 32'h0000_0013);
        checkOutput("rst_pc_current", pc_current, 32'h0000_0000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Scenario 1: first request immediately, first instruction two cycles later.
        @(negedge clk);
        checkOutput("s1_first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        checkOutput("s1_first_req_addr", bus.imem_req_addr, 32'h0000_0000);
        @(negedge clk);
        checkOutput("s1_no_instr_yet", {31'b0, instr_valid}, 32'd0);
        checkOutput("s1_second_req_addr", bus.imem_req_addr, 32'h0000_0004);
        @(negedge clk);
        checkOutput("s1_first_instr_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("s1_first_pc", pc_current, 32'h0000_0000);
        checkOutput("s1_first_instr", instr, 32'h5A00_0003);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 15);

        // Scenario 2: decode stalls, fetch stops once credits are used up.
        instr_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 10);
        @(negedge clk);
        checkOutput("s2_stalled_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        checkOutput("s2_stalled_instr_valid", {31'b0, instr_valid}, 32'd1);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 20);

        // Scenario 3: redirect with slow memory so responses are still in flight.
        lat = 3;
        applyStimulus(1'b0, 32'h0, 12);
        applyStimulus(1'b1, 32'h0000_0100, 1);
        jmp_occur = 1'b0;
        waitValid("s3");
        checkOutput("s3_target_pc", pc_current, 32'h0000_0100);
        checkOutput("s3_target_instr", instr, 32'h5A00_0103);
        @(posedge clk); #1;
        lat = 1;
        applyStimulus(1'b0, 32'h0, 10);

        // Scenario 4: two-cycle pulse, only the first target counts.
        applyStimulus(1'b1, 32'h0000_0200, 1);
        applyStimulus(1'b1, 32'h0000_0008, 1);
        jmp_occur = 1'b0;
        @(negedge clk);
        checkOutput("s4_restart_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        checkOutput("s4_restart_addr", bus.imem_req_addr, 32'h0000_0200);
        waitValid("s4");
        checkOutput("s4_target_pc", pc_current, 32'h0000_0200);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 10);

        // Scenario 5: redirect lands on a cycle with a response arriving.
        jmp_occur = 1'b1;
        pc_jmpto  = 32'h0000_0300;
        @(negedge clk);
        checkOutput("s5_rsp_same_cycle", {31'b0, bus.imem_rsp_valid}, 32'd1);
        @(posedge clk); #1;
        jmp_occur = 1'b0;
        waitValid("s5");
        checkOutput("s5_target_pc", pc_current, 32'h0000_0300);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 10);

        // Scenario 6: unaligned target near the top of memory wraps to zero.
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1);
        jmp_occur = 1'b0;
        @(negedge clk);
        checkOutput("s6_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        checkOutput("s6_wrap_addr", bus.imem_req_addr, 32'h0000_0000);
        waitValid("s6");
        checkOutput("s6_top_pc", pc_current, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 10);

        // Mixed traffic: ready throttling, varying latency and occasional redirects.
        for (int i = 0; i < 150; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready        = ($urandom_range(0, 2) != 0);
            lat                = $urandom_range(1, 3);
            applyStimulus((i % 30 == 15) || (i % 60 == 16), $urandom, 1);
        end
        bus.imem_req_ready = 1'b1;
        instr_ready        = 1'b1;
        applyStimulus(1'b0, 32'h0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
